// File: rtl/sample_packer.sv
`default_nettype none
// ============================================================================
// Module   : sample_packer
// Purpose  : Samples the probe inputs at a divided rate, packs WORD_BITS
//            consecutive samples per enabled channel into one word and
//            streams the words, lowest channel first, over valid/ready.
// Options  : SAMPLE_PACKER_TEST_PATTERN_EN - an all-zero channel mask at
//            start selects an internal counter as the sample source and
//            enables every channel.
// Revision : 1.0 - initial release
// ============================================================================
module sample_packer #(
  parameter int NUM_CH    = 16,
  parameter int WORD_BITS = 16,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 acq_enable,
  input  logic [DIV_WIDTH-1:0] clock_divisor,
  input  logic [NUM_CH-1:0]    channel_enable,
  input  logic [NUM_CH-1:0]    sample_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_BITS-1:0] out_data,
  output logic [3:0]           out_channel,
  output logic                 out_last,
  output logic                 overflow,
  output logic                 sample_strobe,
  output logic                 busy
);

  localparam int BIT_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam logic [BIT_W-1:0] C_LAST_BIT = BIT_W'(WORD_BITS - 1);

  logic                                acq_q;
  logic [DIV_WIDTH-1:0]                div_q, div_d;
  logic [BIT_W-1:0]                    bit_q, bit_d;
  logic [NUM_CH-1:0][WORD_BITS-1:0]    shreg_q, shreg_d;
  logic [NUM_CH-1:0][WORD_BITS-1:0]    hold_q, hold_d;
  logic [NUM_CH-1:0]                   mask_q, mask_d;
  logic [NUM_CH-1:0]                   pend_q, pend_d;
  logic                                ovf_q, ovf_d;
  logic [NUM_CH-1:0]                   tp_cnt_q, tp_cnt_d;
  logic                                tp_q, tp_d;

  logic                 running, start, strobe, blk_done, handshake, one_left;
  logic [DIV_WIDTH-1:0] div_eff;
  logic [BIT_W-1:0]     bit_eff;
  logic [NUM_CH-1:0]    mask_eff, samp;
  logic [3:0]           sel;

  // Reset also forces the level-derived outputs low, so running is gated by rst_n.
  assign running = acq_enable & rst_n;
  assign start   = running & ~acq_q;

  // Next-state logic: divider, shift registers, block hand-off and drain.
  always_comb begin
    div_d    = div_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    hold_d   = hold_q;
    mask_d   = mask_q;
    pend_d   = pend_q;
    ovf_d    = ovf_q;
    tp_cnt_d = '0;
    tp_d     = 1'b0;
    sel      = '0;

    // On the start cycle the run state is taken as freshly cleared.
    div_eff = start ? '0 : div_q;
    bit_eff = start ? '0 : bit_q;
`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
    tp_d     = start ? (channel_enable == '0) : tp_q;
    tp_cnt_d = start ? '0 : tp_cnt_q;
    mask_eff = start ? (tp_d ? '1 : channel_enable) : mask_q;
    samp     = tp_d ? tp_cnt_d : sample_in;
    if (running && (div_eff == '0)) begin
      tp_cnt_d = tp_cnt_d + 1'b1;
    end
`else
    mask_eff = start ? channel_enable : mask_q;
    samp     = sample_in;
`endif
    strobe   = running && (div_eff == '0);
    blk_done = strobe && (bit_eff == C_LAST_BIT) && (mask_eff != '0);

    if (start) begin
      shreg_d = '0;
      ovf_d   = 1'b0;
      mask_d  = channel_enable;
`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
      mask_d  = mask_eff;
`endif
    end

    if (running) begin
      div_d = (div_eff >= clock_divisor) ? '0 : div_eff + 1'b1;
      bit_d = strobe ? bit_eff + 1'b1 : bit_eff;
    end else begin
      div_d = '0;
      bit_d = '0;
    end

    if (strobe) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (mask_eff[c]) begin
          shreg_d[c] = {samp[c], shreg_d[c][WORD_BITS-1:1]};
        end
      end
    end

    // Lowest pending channel is the one presented.
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (pend_q[c]) begin
        sel = 4'(c);
      end
    end
    one_left  = (pend_q & (pend_q - 1'b1)) == '0;
    handshake = (pend_q != '0) && out_ready;
    if (handshake) begin
      pend_d[sel] = 1'b0;
    end

    // A finished block needs the holding buffer free by the end of this cycle.
    if (blk_done) begin
      if ((pend_q == '0) || (handshake && one_left)) begin
        hold_d = shreg_d;
        pend_d = mask_eff;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acq_q    <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      hold_q   <= '0;
      mask_q   <= '0;
      pend_q   <= '0;
      ovf_q    <= 1'b0;
      tp_cnt_q <= '0;
      tp_q     <= 1'b0;
    end else begin
      acq_q    <= acq_enable;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      hold_q   <= hold_d;
      mask_q   <= mask_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      tp_cnt_q <= tp_cnt_d;
      tp_q     <= tp_d;
    end
  end

  // Output stage: payload fields read zero whenever nothing is offered.
  always_comb begin
    out_valid     = (pend_q != '0);
    out_data      = out_valid ? hold_q[sel] : '0;
    out_channel   = out_valid ? sel : 4'd0;
    out_last      = out_valid && one_left;
    overflow      = ovf_q;
    sample_strobe = strobe;
    busy          = running || out_valid;
  end

endmodule
`default_nettype wire

// File: tb/tb_sample_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sample_packer
// Purpose  : Directed self-checking bench for sample_packer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sample_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        acq_enable;
  logic [7:0]  clock_divisor;
  logic [15:0] channel_enable;
  logic [15:0] sample_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_channel;
  logic        out_last;
  logic        overflow;
  logic        sample_strobe;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sample_packer dut (
    .clk(clk), .rst_n(rst_n), .acq_enable(acq_enable),
    .clock_divisor(clock_divisor), .channel_enable(channel_enable),
    .sample_in(sample_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_channel(out_channel), .out_last(out_last),
    .overflow(overflow), .sample_strobe(sample_strobe), .busy(busy)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    acq_enable = 1'b0;
    repeat (n) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; acq_enable = 1'b1; clock_divisor = 8'd0;
    channel_enable = 16'h0001; sample_in = 16'hFFFF; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (sample_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got=%b exp=0", sample_strobe); end
    checks++; if ({overflow, out_data, out_channel, out_last} !== 22'd0) begin
      errors++; $display("FAIL reset_outs got=%h exp=0", {overflow, out_data, out_channel, out_last}); end
    acq_enable = 1'b0;
    step(); rst_n = 1'b1;
    step();
  endtask

  task automatic test_alternating();
    clock_divisor = 8'd0; channel_enable = 16'h0001; out_ready = 1'b1;
    acq_enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sample_in = (i % 2 == 1) ? 16'h0001 : 16'h0000;
      @(negedge clk);
      if (i == 0 || i == 15) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL alt_early_valid i=%0d got=%b exp=0", i, out_valid); end
      end
      step();
    end
    acq_enable = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== 16'hAAAA || out_channel !== 4'd0 || out_last !== 1'b1) begin
      errors++; $display("FAIL alt_word got v=%b d=%h ch=%0d l=%b exp v=1 d=aaaa ch=0 l=1", out_valid, out_data, out_channel, out_last); end
    step();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL alt_after got v=%b busy=%b exp 0 0", out_valid, busy); end
    idle(2);
  endtask

  task automatic test_multi_channel();
    logic [3:0] exp_ch [3];
    exp_ch[0] = 4'd0; exp_ch[1] = 4'd8; exp_ch[2] = 4'd15;
    clock_divisor = 8'd0; channel_enable = 16'h8101; sample_in = 16'hFFFF; out_ready = 1'b1;
    acq_enable = 1'b1;
    repeat (16) step();
    acq_enable = 1'b0;
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_data !== 16'hFFFF || out_channel !== exp_ch[w] || out_last !== (w == 2)) begin
        errors++; $display("FAIL multi_word%0d got v=%b d=%h ch=%0d l=%b exp v=1 d=ffff ch=%0d l=%b",
                           w, out_valid, out_data, out_channel, out_last, exp_ch[w], (w == 2)); end
      step();
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL multi_end got v=%b exp=0", out_valid); end
    idle(2);
  endtask

  task automatic test_divider();
    clock_divisor = 8'd3; channel_enable = 16'h0001; sample_in = 16'h0000; out_ready = 1'b1;
    acq_enable = 1'b1;
    for (int cyc = 0; cyc < 64; cyc++) begin
      @(negedge clk);
      checks++; if (sample_strobe !== (cyc % 4 == 0)) begin
        errors++; $display("FAIL div_strobe cyc=%0d got=%b exp=%b", cyc, sample_strobe, (cyc % 4 == 0)); end
      if (cyc == 60 || cyc == 61) begin
        checks++; if (out_valid !== (cyc == 61)) begin
          errors++; $display("FAIL div_valid cyc=%0d got=%b exp=%b", cyc, out_valid, (cyc == 61)); end
      end
      step();
    end
    idle(3);
  endtask

  task automatic test_overflow();
    clock_divisor = 8'd0; channel_enable = 16'h0001; out_ready = 1'b0;
    acq_enable = 1'b1;
    for (int i = 0; i < 32; i++) begin
      sample_in = (i < 16) ? 16'hFFFF : 16'h0000;
      @(negedge clk);
      if (i == 31) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", overflow); end
      end
      step();
    end
    acq_enable = 1'b0;
    @(negedge clk);
    checks++; if (overflow !== 1'b1 || out_valid !== 1'b1 || out_data !== 16'hFFFF) begin
      errors++; $display("FAIL ovf_set got ovf=%b v=%b d=%h exp ovf=1 v=1 d=ffff", overflow, out_valid, out_data); end
    step();
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== 16'hFFFF) begin
      errors++; $display("FAIL ovf_deliver got v=%b d=%h exp v=1 d=ffff", out_valid, out_data); end
    step();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || overflow !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL ovf_after got v=%b ovf=%b busy=%b exp 0 1 0", out_valid, overflow, busy); end
    idle(2);
  endtask

  task automatic test_back_to_back();
    clock_divisor = 8'd0; channel_enable = 16'h0003; out_ready = 1'b0;
    acq_enable = 1'b1;
    for (int i = 0; i < 32; i++) begin
      sample_in = (i < 16) ? 16'hFFFF : 16'h0000;
      out_ready = (i >= 30);
      @(negedge clk);
      if (i == 31) begin
        checks++; if (out_valid !== 1'b1 || out_channel !== 4'd1 || out_last !== 1'b1 || out_data !== 16'hFFFF) begin
          errors++; $display("FAIL b2b_final got v=%b ch=%0d l=%b d=%h exp v=1 ch=1 l=1 d=ffff",
                             out_valid, out_channel, out_last, out_data); end
      end
      step();
    end
    acq_enable = 1'b0;
    @(negedge clk);
    checks++; if (overflow !== 1'b0 || out_valid !== 1'b1 || out_channel !== 4'd0 || out_data !== 16'h0000 || out_last !== 1'b0) begin
      errors++; $display("FAIL b2b_new got ovf=%b v=%b ch=%0d d=%h l=%b exp ovf=0 v=1 ch=0 d=0000 l=0",
                         overflow, out_valid, out_channel, out_data, out_last); end
    step();
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_channel !== 4'd1 || out_last !== 1'b1) begin
      errors++; $display("FAIL b2b_second got v=%b ch=%0d l=%b exp v=1 ch=1 l=1", out_valid, out_channel, out_last); end
    idle(3);
  endtask

  task automatic test_zero_mask();
    clock_divisor = 8'd0; channel_enable = 16'h0000; out_ready = 1'b1; sample_in = 16'hFFFF;
    acq_enable = 1'b1;
    repeat (16) step();
    acq_enable = 1'b0;
    @(negedge clk);
`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
    checks++; if (out_valid !== 1'b1 || out_channel !== 4'd0 || out_data !== 16'hAAAA) begin
      errors++; $display("FAIL zmask_tp got v=%b ch=%0d d=%h exp v=1 ch=0 d=aaaa", out_valid, out_channel, out_data); end
    repeat (16) step();
`else
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL zmask_none got v=%b busy=%b exp 0 0", out_valid, busy); end
`endif
    idle(2);
  endtask

  task automatic test_reset_mid_drain();
    clock_divisor = 8'd0; channel_enable = 16'h0003; sample_in = 16'hFFFF; out_ready = 1'b0;
    acq_enable = 1'b1;
    repeat (32) step();
    acq_enable = 1'b0;
    @(negedge clk);
    checks++; if (overflow !== 1'b1 || out_valid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL rst_pre got ovf=%b v=%b busy=%b exp 1 1 1", overflow, out_valid, busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0 || out_data !== 16'h0000) begin
      errors++; $display("FAIL rst_async got v=%b ovf=%b busy=%b d=%h exp 0 0 0 0000", out_valid, overflow, busy, out_data); end
    step();
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL rst_residual i=%0d got v=%b busy=%b exp 0 0", i, out_valid, busy); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_alternating();
    test_multi_channel();
    test_divider();
    test_overflow();
    test_back_to_back();
    test_zero_mask();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sample_packer.md
Name: sample_packer

Overview:
Acquisition datapath stage directly downstream of the register/control block. It consumes acq_enable, clock_divisor and channel_enable and samples the 16 probe inputs at the divided rate. It packs 16 consecutive samples of each enabled channel into one 16-bit word. It then streams one word per enabled channel, lowest channel first, over a valid/ready interface to the capture FIFO.

Parameters:
NUM_CH, 16, number of probe channels (also width of channel_enable and sample_in)
WORD_BITS, 16, samples per packed word (power of two)
DIV_WIDTH, 8, width of clock_divisor

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active-low
acq_enable  in  1  acquisition run; level
clock_divisor  in  DIV_WIDTH  sample period = clock_divisor+1 clk cycles
channel_enable  in  NUM_CH  channel mask; bit c enables channel c
sample_in  in  NUM_CH  probe inputs, already synchronous to clk
out_valid  out  1  word available
out_ready  in  1  consumer accepts word
out_data  out  WORD_BITS  packed samples; bit k = k-th sample of block
out_channel  out  4  channel index of out_data
out_last  out  1  last word of current block
overflow  out  1  sticky: a block was dropped
sample_strobe  out  1  high in cycles where a sample is taken
busy  out  1  acquisition running or drain pending

Behaviour:
- Reset (rst_n low, async): all outputs 0. Divider, bit counter, shift registers, latched mask, holding buffer and pending mask all cleared.
- Start: on the first clk edge with acq_enable=1 after it was 0:
  - channel_enable latched into run_mask; later changes are ignored until the next start.
  - div_cnt=0, bit_cnt=0, shift registers cleared, overflow cleared.
  - That cycle is the first strobe.
- Divider: while running, strobe when div_cnt==0. div_cnt increments and wraps to 0 after reaching clock_divisor. clock_divisor is sampled each cycle; a decrease below div_cnt wraps on the next compare. Divisor 0 gives a strobe every cycle.
- Sampling: on strobe, for each channel with run_mask[c]=1, shreg[c] <= {sample_in[c], shreg[c][WORD_BITS-1:1]}. bit_cnt increments modulo WORD_BITS. run_mask=0: strobes still counted, nothing shifted, no block produced.
- Block complete: on the strobe where bit_cnt==WORD_BITS-1 and run_mask!=0, the new shifted values are the block.
  - If the holding buffer is free, or its final handshake occurs in this same cycle: block copied to hold, and pending <= run_mask.
  - Otherwise: overflow <= 1 (sticky), block dropped, hold unchanged.
- Drain:
  - out_valid = (pending != 0).
  - c* = lowest set bit of pending; out_data = hold[c*], out_channel = c*, out_last = (pending has one bit set).
  - On out_valid && out_ready, clear pending[c*].
  - out_data, out_channel and out_last read 0 when out_valid=0.
  - Outputs are stable while valid && !ready.
- Latency: out_valid rises the cycle after the completing strobe; with out_ready=1, consecutive words issue one per cycle.
- Stop (acq_enable falls): strobes stop, partial block discarded, bit_cnt cleared. A pending drain completes normally. overflow holds its value until the next start.
- busy = running || pending != 0.
- acq_enable toggling 1→0→1 mid-drain: drain continues. The new run may overflow if drain is still pending when its first block completes.

Optional Feature:
SAMPLE_PACKER_TEST_PATTERN_EN:
- Defined: when acq_enable is high and channel_enable==16'h0000 at start, sample_in is replaced by an internal 16-bit counter. The counter clears at start and increments on each strobe. run_mask is forced to 16'hFFFF.
- Undefined: no counter logic; mask 0 behaves as specified above (no output).

Test Plan:
- Divisor 0, mask 16'h0001, sample_in[0] = strobe index & 1, out_ready=1 → one word 16'hAAAA, channel 0, out_last=1, out_valid one cycle after the 16th strobe.
- Divisor 0, mask 16'h8101, sample_in=16'hFFFF → three words 16'hFFFF on channels 0, 8, 15 in consecutive cycles; out_last only on channel 15.
- Divisor 3, mask 16'h0001 → sample_strobe every 4th cycle starting at the start cycle (cycles 0, 4, …, 60); out_valid rises at cycle 61.
- out_ready=0, mask 16'h0001, 32 strobes → overflow=1 at the 32nd strobe; the held word is the first block; after out_ready=1, exactly one word is delivered.
- Final handshake coinciding with the next block completion, mask 16'h0003, divisor 0 → no overflow; the new block is presented the next cycle.
- rst_n pulsed low mid-drain → out_valid, overflow and busy drop immediately (asynchronously); after release, no residual words.
